// File: rtl/pdm_decimator.sv
// PDM microphone front end: drives mic_clk, synchronizes mic_data and decimates
// the 1-bit stream through a 3rd-order CIC into 10-bit signed PCM samples.
module pdm_decimator #(
  parameter int HALF_DIV = 50,
  parameter int DECIM    = 64,
  parameter int WARMUP   = 3
) (
  input  logic       clk_100,
  input  logic       rst_n,
  input  logic       enable,
  input  logic       mic_data,
  output logic       mic_clk,
  output logic       mic_lrsel,
  output logic [9:0] pcm_data,
  output logic       pcm_valid,
  output logic       pcm_sat
);
  localparam int DivW  = $clog2(HALF_DIV + 1);
  localparam int DecW  = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam int WarmW = $clog2(WARMUP + 2);
  localparam int AccW  = 20;
  localparam int Shift = 9;

  typedef enum logic [1:0] {IDLE, WARM, RUN} state_e;

  state_e                 state_q, state_d;
  logic [DivW-1:0]        divCnt_q, divCnt_d;
  logic                   micClk_q, micClk_d;
  logic                   sync1_q, sync2_q;
  logic                   sampleEv_q, sampleEv_d;
  logic [DecW-1:0]        decCnt_q, decCnt_d;
  logic [WarmW-1:0]       warmCnt_q, warmCnt_d;
  logic signed [AccW-1:0] int1_q, int1_d, int2_q, int2_d, int3_q, int3_d;
  logic signed [AccW-1:0] dly1_q, dly1_d, dly2_q, dly2_d, dly3_q, dly3_d;
  logic                   combPend_q, combPend_d;
  logic                   emitPend_q, emitPend_d;
  logic [9:0]             pcmData_q, pcmData_d;
  logic                   pcmValid_q, pcmValid_d;
  logic                   pcmSat_q, pcmSat_d;

  logic                   active;
  logic signed [AccW-1:0] sampleVal, comb1, comb2, comb3, scaled;

  // Synchronous reset wins over everything, including a pending output strobe.
  always_ff @(posedge clk_100) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      divCnt_q   <= '0;
      micClk_q   <= 1'b0;
      sync1_q    <= 1'b0;
      sync2_q    <= 1'b0;
      sampleEv_q <= 1'b0;
      decCnt_q   <= '0;
      warmCnt_q  <= '0;
      int1_q     <= '0;
      int2_q     <= '0;
      int3_q     <= '0;
      dly1_q     <= '0;
      dly2_q     <= '0;
      dly3_q     <= '0;
      combPend_q <= 1'b0;
      emitPend_q <= 1'b0;
      pcmData_q  <= '0;
      pcmValid_q <= 1'b0;
      pcmSat_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      divCnt_q   <= divCnt_d;
      micClk_q   <= micClk_d;
      sync1_q    <= mic_data;
      sync2_q    <= sync1_q;
      sampleEv_q <= sampleEv_d;
      decCnt_q   <= decCnt_d;
      warmCnt_q  <= warmCnt_d;
      int1_q     <= int1_d;
      int2_q     <= int2_d;
      int3_q     <= int3_d;
      dly1_q     <= dly1_d;
      dly2_q     <= dly2_d;
      dly3_q     <= dly3_d;
      combPend_q <= combPend_d;
      emitPend_q <= emitPend_d;
      pcmData_q  <= pcmData_d;
      pcmValid_q <= pcmValid_d;
      pcmSat_q   <= pcmSat_d;
    end
  end

  // sampleEv_q marks the cycle in which mic_clk has just fallen.
  always_comb begin
    state_d    = state_q;
    divCnt_d   = divCnt_q;
    micClk_d   = micClk_q;
    sampleEv_d = 1'b0;
    decCnt_d   = decCnt_q;
    warmCnt_d  = warmCnt_q;
    int1_d     = int1_q;
    int2_d     = int2_q;
    int3_d     = int3_q;
    dly1_d     = dly1_q;
    dly2_d     = dly2_q;
    dly3_d     = dly3_q;
    combPend_d = 1'b0;
    emitPend_d = 1'b0;
    pcmData_d  = pcmData_q;
    pcmValid_d = 1'b0;
    pcmSat_d   = pcmSat_q;

    active    = (state_q != IDLE) && enable;
    sampleVal = sync2_q ? 20'sd1 : -20'sd1;
    comb1     = int3_q - dly1_q;
    comb2     = comb1 - dly2_q;
    comb3     = comb2 - dly3_q;
    scaled    = comb3 >>> Shift;

    if (!active) begin
      state_d   = (state_q == IDLE && enable) ? ((WARMUP == 0) ? RUN : WARM) : IDLE;
      divCnt_d  = '0;
      micClk_d  = 1'b0;
      decCnt_d  = '0;
      warmCnt_d = '0;
      int1_d    = '0;
      int2_d    = '0;
      int3_d    = '0;
      dly1_d    = '0;
      dly2_d    = '0;
      dly3_d    = '0;
    end else begin
      if (int'(divCnt_q) == HALF_DIV - 1) begin
        divCnt_d   = '0;
        micClk_d   = ~micClk_q;
        sampleEv_d = micClk_q;
      end else begin
        divCnt_d = divCnt_q + 1'b1;
      end

      if (sampleEv_q) begin
        int1_d = int1_q + sampleVal;
        int2_d = int2_q + int1_d;
        int3_d = int3_q + int2_d;
        if (int'(decCnt_q) == DECIM - 1) begin
          decCnt_d   = '0;
          combPend_d = 1'b1;
          emitPend_d = (state_q == RUN);
          if (state_q == WARM) begin
            if (int'(warmCnt_q) == WARMUP - 1) state_d = RUN;
            else warmCnt_d = warmCnt_q + 1'b1;
          end
        end else begin
          decCnt_d = decCnt_q + 1'b1;
        end
      end

      // Warm-up frames still advance the comb delays so the first emitted sample is settled.
      if (combPend_q) begin
        dly1_d = int3_q;
        dly2_d = comb1;
        dly3_d = comb2;
        if (emitPend_q) begin
          pcmValid_d = 1'b1;
          if (scaled > 20'sd511) begin
            pcmData_d = 10'h1FF;
            pcmSat_d  = 1'b1;
          end else if (scaled < -20'sd512) begin
            pcmData_d = 10'h200;
            pcmSat_d  = 1'b1;
          end else begin
            pcmData_d = scaled[9:0];
            pcmSat_d  = 1'b0;
          end
        end
      end
    end
  end

  assign mic_clk   = micClk_q;
  assign mic_lrsel = 1'b0;
  assign pcm_data  = pcmData_q;
  assign pcm_valid = pcmValid_q;
  assign pcm_sat   = pcmSat_q;

endmodule

// File: tb/tb_pdm_decimator.sv
// Directed bench for pdm_decimator: clock generation, warm-up, DC and
// alternating PDM patterns, enable drop, in-flight suppression and reset.
`timescale 1ns/1ps
module tb_pdm_decimator;
  // Short divider keeps the run brief; DECIM and WARMUP stay at their defaults.
  localparam int HalfDiv     = 5;
  localparam int Decim       = 64;
  localparam int Warmup      = 3;
  localparam int FramePeriod = 2 * HalfDiv * Decim;
  localparam int FirstValid  = FramePeriod * (Warmup + 1) + 2;

  logic       clk_100 = 1'b0;
  logic       rst_n;
  logic       enable;
  logic       mic_data;
  logic       mic_clk;
  logic       mic_lrsel;
  logic [9:0] pcm_data;
  logic       pcm_valid;
  logic       pcm_sat;

  int   compared     = 0;
  int   mismatched   = 0;
  int   cycleNo      = 0;
  int   markCycle    = 0;
  int   validCount   = 0;
  int   lastValidRel = -1;
  int   lrselErrs    = 0;
  bit   toggleMode   = 1'b0;
  logic prevMicClk   = 1'b0;

  pdm_decimator #(
    .HALF_DIV(HalfDiv),
    .DECIM   (Decim),
    .WARMUP  (Warmup)
  ) dut (
    .clk_100  (clk_100),
    .rst_n    (rst_n),
    .enable   (enable),
    .mic_data (mic_data),
    .mic_clk  (mic_clk),
    .mic_lrsel(mic_lrsel),
    .pcm_data (pcm_data),
    .pcm_valid(pcm_valid),
    .pcm_sat  (pcm_sat)
  );

  always #5 clk_100 = ~clk_100;

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: observed no finish, expected finish before 1 ms");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %0d (0x%0h), expected %0d (0x%0h)", tag, observed, observed, expected, expected);
    end
  endtask

  // Advances whole clocks, samples 1 ns after each edge and toggles mic_data on mic_clk rises.
  task automatic applyStimulus(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk_100);
      #1;
      cycleNo++;
      if (mic_lrsel !== 1'b0) lrselErrs++;
      if (pcm_valid === 1'b1) begin
        validCount++;
        lastValidRel = cycleNo - markCycle;
      end
      if (toggleMode && mic_clk === 1'b1 && prevMicClk === 1'b0) mic_data = ~mic_data;
      prevMicClk = mic_clk;
    end
  endtask

  task automatic runTo(input int rel);
    if (markCycle + rel > cycleNo) applyStimulus(markCycle + rel - cycleNo);
  endtask

  task automatic waitValid(input int limit, output int rel);
    int startCount;
    startCount = validCount;
    for (int i = 0; i < limit && validCount == startCount; i++) applyStimulus(1);
    rel = (validCount != startCount) ? lastValidRel : -1;
  endtask

  task automatic startCapture();
    enable = 1'b1;
    applyStimulus(1);
    markCycle = cycleNo;
  endtask

  initial begin
    int rel;
    int vcSnap;

    rst_n    = 1'b0;
    enable   = 1'b0;
    mic_data = 1'b1;
    applyStimulus(3);
    checkOutput("reset_mic_clk", mic_clk, 0);
    checkOutput("reset_pcm_valid", pcm_valid, 0);
    checkOutput("reset_pcm_data", pcm_data, 0);
    checkOutput("reset_pcm_sat", pcm_sat, 0);
    checkOutput("reset_mic_lrsel", mic_lrsel, 0);

    rst_n = 1'b1;
    applyStimulus(20);
    checkOutput("idle_mic_clk", mic_clk, 0);
    checkOutput("idle_no_valid", validCount, 0);

    $display("[TB] constant-one input");
    startCapture();
    runTo(HalfDiv - 1);
    checkOutput("clk_low_before_rise", mic_clk, 0);
    runTo(HalfDiv);
    checkOutput("clk_rise", mic_clk, 1);
    runTo(2 * HalfDiv - 1);
    checkOutput("clk_high_width", mic_clk, 1);
    runTo(2 * HalfDiv);
    checkOutput("clk_fall", mic_clk, 0);
    waitValid(FirstValid + 100, rel);
    checkOutput("ones_first_valid_time", rel, FirstValid);
    checkOutput("ones_data", pcm_data, 10'h1FF);
    checkOutput("ones_sat", pcm_sat, 1);
    applyStimulus(1);
    checkOutput("valid_one_cycle", pcm_valid, 0);
    checkOutput("ones_data_hold", pcm_data, 10'h1FF);
    waitValid(FramePeriod + 100, rel);
    checkOutput("ones_spacing", rel, FirstValid + FramePeriod);
    checkOutput("ones_second_data", pcm_data, 10'h1FF);

    $display("[TB] enable drop twenty events into a frame");
    runTo((Warmup + 2) * FramePeriod + 20 * 2 * HalfDiv + HalfDiv);
    checkOutput("drop_clk_high_before", mic_clk, 1);
    enable = 1'b0;
    vcSnap = validCount;
    applyStimulus(1);
    checkOutput("drop_clk_low", mic_clk, 0);
    checkOutput("drop_data_hold", pcm_data, 10'h1FF);
    applyStimulus(2 * FramePeriod);
    checkOutput("drop_no_valid", validCount, vcSnap);
    checkOutput("drop_clk_stays_low", mic_clk, 0);

    $display("[TB] constant-zero input after re-enable");
    mic_data = 1'b0;
    applyStimulus(4);
    startCapture();
    waitValid(FirstValid + 100, rel);
    checkOutput("zeros_first_valid_time", rel, FirstValid);
    checkOutput("zeros_data", pcm_data, 10'h200);
    checkOutput("zeros_sat", pcm_sat, 0);

    $display("[TB] reset one cycle before a strobe");
    runTo((Warmup + 2) * FramePeriod);
    rst_n  = 1'b0;
    vcSnap = validCount;
    applyStimulus(1);
    checkOutput("rst_pcm_valid", pcm_valid, 0);
    checkOutput("rst_pcm_data", pcm_data, 0);
    checkOutput("rst_pcm_sat", pcm_sat, 0);
    checkOutput("rst_mic_clk", mic_clk, 0);
    rst_n      = 1'b1;
    toggleMode = 1'b1;
    applyStimulus(1);
    markCycle = cycleNo;
    checkOutput("rst_no_late_valid", validCount, vcSnap);

    $display("[TB] alternating input after reset");
    waitValid(FirstValid + 100, rel);
    checkOutput("alt_first_valid_time", rel, FirstValid);
    checkOutput("alt_data", pcm_data, 0);
    checkOutput("alt_sat", pcm_sat, 0);
    waitValid(FramePeriod + 100, rel);
    checkOutput("alt_spacing", rel, FirstValid + FramePeriod);
    checkOutput("alt_second_data", pcm_data, 0);

    $display("[TB] enable drop with a strobe in flight");
    runTo((Warmup + 3) * FramePeriod + 1);
    enable = 1'b0;
    vcSnap = validCount;
    applyStimulus(5);
    checkOutput("inflight_suppressed", validCount, vcSnap);
    checkOutput("inflight_clk_low", mic_clk, 0);

    checkOutput("lrsel_tied_low", lrselErrs, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/pdm_decimator.md
PDM_DECIMATOR -- requirements
Module: pdm_decimator

Interface
REQ-001 The block SHALL provide parameter HALF_DIV, default 50: clk_100 cycles per mic_clk half-period.
REQ-002 The block SHALL provide parameter DECIM, default 64: PDM bits per PCM sample (power of two).
REQ-003 The block SHALL provide parameter WARMUP, default 3: decimated outputs discarded after start.
REQ-004 The block SHALL have port clk_100, input, 1: system clock, 100 MHz, all logic on rising edge.
REQ-005 The block SHALL have port rst_n, input, 1: reset, synchronous, active-low.
REQ-006 The block SHALL have port enable, input, 1: run capture when high, level-sensitive.
REQ-007 The block SHALL have port mic_data, input, 1: asynchronous PDM bit from the microphone.
REQ-008 The block SHALL have port mic_clk, output, 1: PDM clock to the microphone.
REQ-009 The block SHALL have port mic_lrsel, output, 1: channel select, tied 0.
REQ-010 The block SHALL have port pcm_data, output, 10: signed two's-complement PCM sample.
REQ-011 The block SHALL have port pcm_valid, output, 1: one-cycle strobe, pcm_data valid.
REQ-012 The block SHALL have port pcm_sat, output, 1: pcm_data was clipped; meaningful only with pcm_valid.

Function
REQ-013 The clock divider SHALL count 0..HALF_DIV-1 and toggle mic_clk on the terminal count, giving a 100-cycle period with 50 cycles high (1 MHz).
REQ-014 mic_data SHALL pass through a 2-flop synchronizer before use.
REQ-015 A sample event SHALL occur in the clk_100 cycle in which mic_clk toggles 1->0; the synchronized bit is mapped to +1 (bit 1) or -1 (bit 0).
REQ-016 The filter SHALL be a 3rd-order CIC (3 integrators at sample rate, 3 combs with differential delay 1 at output rate), all 20-bit signed, modular wrap-around with no saturation inside the filter.
REQ-017 A decimation counter SHALL count sample events 0..DECIM-1; the event at count DECIM-1 completes a frame.
REQ-018 The comb stage SHALL be evaluated exactly 1 cycle after a frame-completing sample event; pcm_valid SHALL assert exactly 2 cycles after that event.
REQ-019 Output scaling SHALL be an arithmetic right shift of the comb result by 9 bits, then saturation to [-512, +511]; pcm_sat=1 when clipping occurred, otherwise 0.
REQ-020 pcm_data and pcm_sat SHALL hold their values until the next pcm_valid.
REQ-021 The first WARMUP completed frames after enable rises or after reset SHALL NOT produce pcm_valid; comb delay registers still update on them.
REQ-022 In steady state, pcm_valid SHALL assert once every DECIM*2*HALF_DIV = 6400 cycles (15.625 kHz).
REQ-023 The control FSM SHALL have states IDLE (enable low), WARM (frames discarded), RUN (output active); transitions: IDLE->WARM when enable=1; WARM->RUN after WARMUP frames; WARM/RUN->IDLE on the cycle enable samples 0.
REQ-024 In IDLE, mic_clk SHALL be held 0, and the divider, decimation counter, integrators, combs and warm-up counter SHALL be cleared; pcm_valid=0; pcm_data and pcm_sat hold their values.
REQ-025 Enable deassertion mid-frame SHALL abandon the partial frame with no pcm_valid; an in-flight pcm_valid (frame already complete) SHALL be suppressed.

Reset
REQ-026 With rst_n=0 at a clk_100 edge, all state SHALL clear: FSM=IDLE, mic_clk=0, mic_lrsel=0, pcm_data=0, pcm_valid=0, pcm_sat=0, all counters and filter registers 0.
REQ-027 Reset asserted mid-operation SHALL take priority over enable and all other activity in the same cycle; pcm_valid SHALL be 0 in the cycle after reset regardless of pending frames.

Verification
REQ-028 Reset then enable=1: mic_clk rises 50 cycles after the FSM leaves IDLE, period 100, duty 50%; mic_lrsel=0 throughout.
REQ-029 mic_data constant 1: no pcm_valid for the first 3 frames; 4th frame -> pcm_data=+511, pcm_sat=1; following strobes spaced exactly 6400 cycles.
REQ-030 mic_data constant 0: first valid output pcm_data=-512, pcm_sat=0.
REQ-031 mic_data toggling every mic_clk period (alternating +1/-1): all valid outputs pcm_data=0, pcm_sat=0.
REQ-032 enable dropped 20 sample events into a RUN frame: no further pcm_valid, mic_clk=0 next cycle; re-enable -> 3 frames discarded again, then correct outputs resume.
REQ-033 rst_n pulsed low 1 cycle before a frame's pcm_valid would fire: no pcm_valid, all outputs 0, warm-up restarts.
